// File: rtl/sntrup_pkg.sv
// Shared constants and FSM encoding for the SNTRUP757 fraction batch sequencer.
package sntrup_pkg;

  localparam int P_DEF  = 757;
  localparam int AW_DEF = 10;
  localparam int DW     = 13;
  localparam int MW     = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LAT   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WACK  = 3'd4,
    ST_WDONE = 3'd5,
    ST_WR    = 3'd6,
    ST_FIN   = 3'd7
  } fsm_state_t;

  function automatic logic is_zero(input logic [DW-1:0] v);
    return (v == {DW{1'b0}});
  endfunction

endpackage

// File: rtl/frac_batch_seq_if.sv
// Bus bundle between the batch sequencer (master) and its RAMs / fraction unit (slave).
interface frac_batch_seq_if
  import sntrup_pkg::*;
#(
  parameter int AW = AW_DEF
) ();

  logic          start;
  logic [MW-1:0] modu;
  logic [AW-1:0] num_addr;
  logic [AW-1:0] den_addr;
  logic [DW-1:0] num_rdata;
  logic [DW-1:0] den_rdata;
  logic          f_start;
  logic [DW-1:0] f_num;
  logic [DW-1:0] f_den;
  logic [MW-1:0] f_modu;
  logic          f_busy;
  logic [DW-1:0] f_modfrac;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_wdata;
  logic          busy;
  logic          done;
  logic          den_zero_err;

  modport master (
    input  start, modu, num_rdata, den_rdata, f_busy, f_modfrac,
    output num_addr, den_addr, f_start, f_num, f_den, f_modu,
           res_we, res_addr, res_wdata, busy, done, den_zero_err
  );

  modport slave (
    output start, modu, num_rdata, den_rdata, f_busy, f_modfrac,
    input  num_addr, den_addr, f_start, f_num, f_den, f_modu,
           res_we, res_addr, res_wdata, busy, done, den_zero_err
  );

endinterface

// File: rtl/frac_batch_ctr.sv
// Coefficient index counter, saturating at P-1 with a last-coefficient flag.
module frac_batch_ctr #(
  parameter int P  = 757,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] idx,
  output logic          last
);

  logic [AW-1:0] idx_q, idx_d;

  assign idx  = idx_q;
  assign last = (idx_q == AW'(P - 1));

  // Saturating at P-1 keeps every issued address inside the batch.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = {AW{1'b0}};
    end else if (inc && !last) begin
      idx_d = idx_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= {AW{1'b0}};
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/frac_batch_seq.sv
// Batch sequencer running P num/den mod modu jobs through the fraction unit.
// Optional feature macro: FRACSEQ_ZERO_SKIP_EN (bypass the unit on zero denominators).
module frac_batch_seq
  import sntrup_pkg::*;
#(
  parameter int P  = P_DEF,
  parameter int AW = AW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  frac_batch_seq_if.master bus
);

  fsm_state_t    state_q, state_d;
  logic [AW-1:0] idx;
  logic          last;
  logic [MW-1:0] modu_q, modu_d;
  logic [DW-1:0] f_num_q, f_num_d, f_den_q, f_den_d, res_q, res_d;
  logic          err_q, err_d, f_start_q, f_start_d, res_we_q, res_we_d;
  logic          busy_q, busy_d, done_q, done_d;
`ifdef FRACSEQ_ZERO_SKIP_EN
  logic          skip_q, skip_d;
`endif

  frac_batch_ctr #(.P(P), .AW(AW)) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_q == ST_IDLE) && bus.start),
    .inc  (state_q == ST_WR),
    .idx  (idx),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = bus.start ? ST_RD : ST_IDLE;
      ST_RD:    state_d = ST_LAT;
`ifdef FRACSEQ_ZERO_SKIP_EN
      ST_LAT:   state_d = is_zero(bus.den_rdata) ? ST_WR : ST_ISSUE;
`else
      ST_LAT:   state_d = ST_ISSUE;
`endif
      ST_ISSUE: state_d = ST_WACK;
      ST_WACK:  state_d = bus.f_busy ? ST_WDONE : ST_WACK;
      ST_WDONE: state_d = bus.f_busy ? ST_WDONE : ST_WR;
      ST_WR:    state_d = last ? ST_FIN : ST_RD;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    f_start_d = (state_d == ST_ISSUE);
    res_we_d  = (state_d == ST_WR);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FIN);
    modu_d    = modu_q;
    f_num_d   = f_num_q;
    f_den_d   = f_den_q;
    res_d     = res_q;
    err_d     = err_q;
    if ((state_q == ST_IDLE) && bus.start) begin
      modu_d = bus.modu;
    end else begin
      modu_d = modu_q;
    end
    if (state_q == ST_LAT) begin
      f_num_d = bus.num_rdata;
      f_den_d = bus.den_rdata;
    end else begin
      f_num_d = f_num_q;
      f_den_d = f_den_q;
    end
    if ((state_q == ST_WDONE) && !bus.f_busy) begin
      res_d = bus.f_modfrac;
`ifdef FRACSEQ_ZERO_SKIP_EN
    end else if ((state_q == ST_LAT) && is_zero(bus.den_rdata)) begin
      res_d = {DW{1'b0}};
`endif
    end else begin
      res_d = res_q;
    end
`ifdef FRACSEQ_ZERO_SKIP_EN
    skip_d = skip_q;
    if (state_q == ST_LAT) begin
      skip_d = is_zero(bus.den_rdata);
    end else begin
      skip_d = skip_q;
    end
    if ((state_q == ST_IDLE) && bus.start) begin
      err_d = 1'b0;
    end else if ((state_q == ST_WR) && skip_q) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      modu_q    <= {MW{1'b0}};
      f_num_q   <= {DW{1'b0}};
      f_den_q   <= {DW{1'b0}};
      res_q     <= {DW{1'b0}};
      err_q     <= 1'b0;
      f_start_q <= 1'b0;
      res_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FRACSEQ_ZERO_SKIP_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      modu_q    <= modu_d;
      f_num_q   <= f_num_d;
      f_den_q   <= f_den_d;
      res_q     <= res_d;
      err_q     <= err_d;
      f_start_q <= f_start_d;
      res_we_q  <= res_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef FRACSEQ_ZERO_SKIP_EN
      skip_q    <= skip_d;
`endif
    end
  end

  assign bus.num_addr     = idx;
  assign bus.den_addr     = idx;
  assign bus.res_addr     = idx;
  assign bus.res_wdata    = res_q;
  assign bus.res_we       = res_we_q;
  assign bus.f_start      = f_start_q;
  assign bus.f_num        = f_num_q;
  assign bus.f_den        = f_den_q;
  assign bus.f_modu       = modu_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.den_zero_err = err_q;

endmodule
